// File: rtl/sd_fifo_tail_b.sv
// sd_fifo_tail_b: zero-bubble FIFO reader over a memory with 1-cycle registered read latency.
// Define SDLIB_TAIL_USAGE_EN to build the registered p_usage counter; otherwise p_usage is tied to 0.
module sd_fifo_tail_b #(
    parameter int width = 8,
    parameter int depth = 16,
    parameter int asz   = $clog2(depth)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [asz:0]     wrptr_head,
    output logic [asz:0]     rdptr_tail,
    output logic             rd_en,
    output logic [asz-1:0]   rd_addr,
    input  logic [width-1:0] mem_rd_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data,
    output logic [asz:0]     p_usage
);
    logic [asz:0]     r_rdptr;
    logic             r_arm;
    logic             r_inflight;
    logic             r_srdy;
    logic [1:0]       r_cnt;
    logic [width-1:0] r_buf0;
    logic [width-1:0] r_buf1;
    logic             w_empty;
    logic             w_xfer;
    logic             w_rd;
    logic [1:0]       w_occ;
    logic [1:0]       w_wpos;

    assign w_empty = r_rdptr == wrptr_head;
    assign w_xfer  = r_srdy & p_drdy;
    // buffered + in-flight words left after this cycle's transfer; never exceeds 2
    assign w_occ   = r_cnt + {1'b0, r_inflight} - {1'b0, w_xfer};
    // r_arm keeps the first cycle after reset release empty and blocks reads during reset
    assign w_rd    = r_arm & ~w_empty & ~w_occ[1];
    assign w_wpos  = r_cnt - {1'b0, w_xfer};

    assign rd_en      = w_rd;
    assign rd_addr    = r_rdptr[asz-1:0];
    assign rdptr_tail = r_rdptr;
    assign p_srdy     = r_srdy;
    assign p_data     = r_buf0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arm      <= 1'b0;
            r_inflight <= 1'b0;
            r_rdptr    <= '0;
            r_cnt      <= 2'd0;
            r_srdy     <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_arm      <= 1'b1;
            r_inflight <= w_rd;
            r_rdptr    <= r_rdptr + {{asz{1'b0}}, w_rd};
            r_cnt      <= w_occ;
            r_srdy     <= w_occ != 2'd0;
            if (r_inflight && w_wpos == 2'd0)
                r_buf0 <= mem_rd_data;
            else if (w_xfer)
                r_buf0 <= r_buf1;
            if (r_inflight && w_wpos == 2'd1)
                r_buf1 <= mem_rd_data;
        end
    end

`ifdef SDLIB_TAIL_USAGE_EN
    logic [asz:0] r_usage;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_usage <= '0;
        else
            r_usage <= (wrptr_head - r_rdptr) + {{asz{1'b0}}, r_inflight} + {{(asz-1){1'b0}}, r_cnt};
    end

    assign p_usage = r_usage;
`else
    assign p_usage = '0;
`endif

endmodule

// File: tb/tb_sd_fifo_tail_b.sv
// tb_sd_fifo_tail_b: directed checks of sd_fifo_tail_b with depth-16 and depth-4 instances
// and behavioural memories with 1-cycle registered read.
module tb_sd_fifo_tail_b;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] wp = '0;
    logic [4:0] rdptr;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rdat = '0;
    logic       p_srdy;
    logic       drdy = 1'b0;
    logic [7:0] p_data;
    logic [4:0] p_usage;
    logic [7:0] mem [16];
    int         wn = 0;

    logic [2:0] wp4 = '0;
    logic [2:0] rp4;
    logic       rd4;
    logic [1:0] addr4;
    logic [7:0] rdat4 = '0;
    logic       srdy4;
    logic       drdy4 = 1'b0;
    logic [7:0] data4;
    logic [2:0] usage4;
    logic [7:0] mem4 [4];

    int total = 0;
    int bad = 0;

`ifdef SDLIB_TAIL_USAGE_EN
    localparam bit USE = 1'b1;
`else
    localparam bit USE = 1'b0;
`endif

    typedef struct {
        int         push;
        logic       drdy;
        logic       rd;
        logic [3:0] addr;
        logic       srdy;
        logic [7:0] data;
        logic [4:0] rp;
    } vec_t;

    vec_t tv [16];

    sd_fifo_tail_b #(.width(8), .depth(16)) u16 (
        .clk(clk), .reset(reset), .wrptr_head(wp), .rdptr_tail(rdptr),
        .rd_en(rd_en), .rd_addr(rd_addr), .mem_rd_data(rdat),
        .p_srdy(p_srdy), .p_drdy(drdy), .p_data(p_data), .p_usage(p_usage)
    );

    sd_fifo_tail_b #(.width(8), .depth(4)) u4 (
        .clk(clk), .reset(reset), .wrptr_head(wp4), .rdptr_tail(rp4),
        .rd_en(rd4), .rd_addr(addr4), .mem_rd_data(rdat4),
        .p_srdy(srdy4), .p_drdy(drdy4), .p_data(data4), .p_usage(usage4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rdat <= mem[rd_addr];
        if (rd4) rdat4 <= mem4[addr4];
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int n);
        for (int k = 0; k < n; k++) begin
            mem[wp[3:0]] = 8'(8'h40 + wn);
            wn++;
            wp = wp + 5'd1;
        end
    endtask

    task automatic step(input int n, input logic d);
        @(posedge clk);
        #1;
        push(n);
        drdy = d;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        wp = '0;
        wn = 0;
        wp4 = '0;
        drdy = 1'b0;
        drdy4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        int got;
        int sent;
        logic [2:0] occ;
        tv[0]  = '{1, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00, 5'd0};
        tv[1]  = '{0, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00, 5'd1};
        tv[2]  = '{0, 1'b1, 1'b0, 4'd1, 1'b1, 8'h40, 5'd1};
        tv[3]  = '{0, 1'b1, 1'b0, 4'd1, 1'b0, 8'h00, 5'd1};
        tv[4]  = '{0, 1'b0, 1'b0, 4'd1, 1'b0, 8'h00, 5'd1};
        tv[5]  = '{5, 1'b0, 1'b1, 4'd1, 1'b0, 8'h00, 5'd1};
        tv[6]  = '{0, 1'b0, 1'b1, 4'd2, 1'b0, 8'h00, 5'd2};
        tv[7]  = '{0, 1'b0, 1'b0, 4'd3, 1'b1, 8'h41, 5'd3};
        tv[8]  = '{0, 1'b0, 1'b0, 4'd3, 1'b1, 8'h41, 5'd3};
        tv[9]  = '{0, 1'b0, 1'b0, 4'd3, 1'b1, 8'h41, 5'd3};
        tv[10] = '{0, 1'b1, 1'b1, 4'd3, 1'b1, 8'h41, 5'd3};
        tv[11] = '{0, 1'b1, 1'b1, 4'd4, 1'b1, 8'h42, 5'd4};
        tv[12] = '{0, 1'b1, 1'b1, 4'd5, 1'b1, 8'h43, 5'd5};
        tv[13] = '{0, 1'b1, 1'b0, 4'd6, 1'b1, 8'h44, 5'd6};
        tv[14] = '{0, 1'b1, 1'b0, 4'd6, 1'b1, 8'h45, 5'd6};
        tv[15] = '{0, 1'b1, 1'b0, 4'd6, 1'b0, 8'h00, 5'd6};

        // reset held low while the head pointer moves
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            wp = wp + 5'd3;
            @(negedge clk);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_srdy", p_srdy, 0);
            chk("rst_rdptr", rdptr, 0);
            chk("rst_data", p_data, 0);
            chk("rst_usage", p_usage, 0);
        end
        reset = 1'b1;
        #1;
        chk("rst_first_rd", rd_en, 0);
        do_reset;

        // asynchronous reset with words buffered and backpressured
        step(3, 1'b0);
        repeat (3) step(0, 1'b0);
        chk("mid_pre_srdy", p_srdy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rd_en", rd_en, 0);
        chk("mid_srdy", p_srdy, 0);
        chk("mid_rdptr", rdptr, 0);
        chk("mid_data", p_data, 0);
        chk("mid_usage", p_usage, 0);
        do_reset;
        repeat (3) begin
            step(0, 1'b1);
            chk("mid_discard", p_srdy, 0);
        end

        // single word then backpressure, cycle by cycle
        for (int i = 0; i < 16; i++) begin
            step(tv[i].push, tv[i].drdy);
            chk($sformatf("vec%0d_rd_en", i), rd_en, tv[i].rd);
            chk($sformatf("vec%0d_addr", i), rd_addr, tv[i].addr);
            chk($sformatf("vec%0d_srdy", i), p_srdy, tv[i].srdy);
            chk($sformatf("vec%0d_rdptr", i), rdptr, tv[i].rp);
            if (tv[i].srdy) chk($sformatf("vec%0d_data", i), p_data, tv[i].data);
        end

        // full-depth streaming with p_drdy held high
        do_reset;
        got = 0;
        for (int c = 0; c < 22; c++) begin
            step(c == 0 ? 16 : 0, 1'b1);
            if (p_srdy) begin
                chk("stream_slot", c, 2 + got);
                chk("stream_data", p_data, 32'h40 + got);
                got++;
            end
        end
        chk("stream_count", got, 16);
        chk("stream_empty_rd", rd_en, 0);

        // usage under backpressure, then after two transfers
        do_reset;
        step(6, 1'b0);
        repeat (5) step(0, 1'b0);
        chk("use_six", p_usage, USE ? 6 : 0);
        chk("use_rdptr2", rdptr, 2);
        chk("use_hold_data", p_data, 8'h40);
        step(0, 1'b1);
        chk("use_xfer0", p_data, 8'h40);
        step(0, 1'b1);
        chk("use_xfer1", p_data, 8'h41);
        repeat (4) step(0, 1'b0);
        chk("use_four", p_usage, USE ? 4 : 0);
        chk("use_rdptr4", rdptr, 4);
        chk("use_next_data", p_data, 8'h42);

        // depth-4 wrap: pointers pass 7 -> 0
        do_reset;
        got = 0;
        sent = 0;
        for (int c = 0; c < 200 && got < 10; c++) begin
            @(posedge clk);
            #1;
            occ = wp4 - rp4;
            if (sent < 10 && occ < 3'd4) begin
                mem4[wp4[1:0]] = 8'(8'h40 + sent);
                wp4 = wp4 + 3'd1;
                sent++;
            end
            drdy4 = (c % 3) != 2;
            @(negedge clk);
            chk("wrap_rd_empty", rd4 && rp4 == wp4, 0);
            if (srdy4 && drdy4) begin
                chk("wrap_data", data4, 32'h40 + got);
                got++;
            end
        end
        chk("wrap_count", got, 10);
        drdy4 = 1'b1;
        repeat (3) step(0, 1'b0);
        chk("wrap_rdptr", rp4, 2);
        chk("wrap_empty_rd", rd4, 0);
        chk("wrap_empty_srdy", srdy4, 0);
        @(posedge clk);
        #1;
        mem4[wp4[1:0]] = 8'h4A;
        wp4 = wp4 + 3'd1;
        @(negedge clk);
        chk("wrap_again_rd", rd4, 1);
        @(negedge clk);
        chk("wrap_again_lat1", srdy4, 0);
        @(negedge clk);
        chk("wrap_again_srdy", srdy4, 1);
        chk("wrap_again_data", data4, 8'h4A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
